// File: rtl/bcd_operand_entry.sv
// Keypad-style BCD operand entry: debounced buttons, 3-digit collection, serial BCD-to-binary.
// Optional ENTRY_SAT_EN: overflow saturates operand to 255 and still strobes op_valid.
module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_in,
  input  logic        btn_push,
  input  logic        btn_enter,
  input  logic        btn_clear,
  output logic [7:0]  operand,
  output logic        op_valid,
  output logic        busy,
  output logic        err,
  output logic [11:0] digits,
  output logic [1:0]  ndig
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTRY,
    CONVERT,
    DONE
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    stable;
  logic [2:0]    ev;
  logic [CW-1:0] cnt [3];
  logic          ev_push;
  logic          ev_enter;
  logic          ev_clear;

  assign raw      = {btn_clear, btn_enter, btn_push};
  assign ev_push  = ev[0];
  assign ev_enter = ev[1];
  assign ev_clear = ev[2];

  // ev is registered in the same edge that flips stable 0->1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      ev     <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ev[i] <= 1'b0;
        if (raw[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]    <= '0;
          stable[i] <= raw[i];
          ev[i]     <= raw[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t      state;
  state_t      state_n;
  logic [9:0]  acc;
  logic [9:0]  acc_n;
  logic [9:0]  acc_step;
  logic [1:0]  k;
  logic [1:0]  k_n;
  logic [3:0]  slot;
  logic [11:0] digits_n;
  logic [1:0]  ndig_n;
  logic [7:0]  operand_n;
  logic        op_valid_n;
  logic        err_n;

  always_comb begin
    slot = 4'd0;
    unique case (k)
      2'd0:    slot = digits[11:8];
      2'd1:    slot = digits[7:4];
      2'd2:    slot = digits[3:0];
      default: slot = 4'd0;
    endcase
  end

  // acc <= 99 before the last step, so 10 bits never wrap
  assign acc_step = acc * 10'd10 + {6'd0, slot};

  always_comb begin
    state_n    = state;
    digits_n   = digits;
    ndig_n     = ndig;
    acc_n      = acc;
    k_n        = k;
    operand_n  = operand;
    op_valid_n = 1'b0;
    err_n      = err;
    unique case (state)
      ENTRY: begin
        if (ev_clear) begin
          digits_n = '0;
          ndig_n   = '0;
          err_n    = 1'b0;
        end else if (ev_enter) begin
          acc_n   = '0;
          k_n     = '0;
          state_n = CONVERT;
        end else if (ev_push && digit_in <= 4'd9 && ndig != 2'd3) begin
          digits_n = {digits[7:0], digit_in};
          ndig_n   = ndig + 2'd1;
        end
      end
      CONVERT: begin
        if (ev_clear) begin
          state_n  = ENTRY;
          digits_n = '0;
          ndig_n   = '0;
          acc_n    = '0;
          k_n      = '0;
        end else begin
          acc_n = acc_step;
          k_n   = k + 2'd1;
          if (k == 2'd2) begin
            k_n     = '0;
            state_n = DONE;
            if (acc_step <= 10'd255) begin
              operand_n  = acc_step[7:0];
              op_valid_n = 1'b1;
            end else begin
              err_n = 1'b1;
`ifdef ENTRY_SAT_EN
              operand_n  = 8'd255;
              op_valid_n = 1'b1;
`endif
            end
          end
        end
      end
      DONE: begin
        state_n  = ENTRY;
        digits_n = '0;
        ndig_n   = '0;
      end
      default: state_n = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTRY;
      digits   <= '0;
      ndig     <= '0;
      acc      <= '0;
      k        <= '0;
      operand  <= '0;
      op_valid <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      digits   <= digits_n;
      ndig     <= ndig_n;
      acc      <= acc_n;
      k        <= k_n;
      operand  <= operand_n;
      op_valid <= op_valid_n;
      err      <= err_n;
      busy     <= (state_n != ENTRY);
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Randomized and directed bench for bcd_operand_entry against a digit-queue model.
// Run with or without ENTRY_SAT_EN defined; the model follows the same macro.
module tb_bcd_operand_entry;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        btn_push = 1'b0;
  logic        btn_enter = 1'b0;
  logic        btn_clear = 1'b0;
  logic [7:0]  operand;
  logic        op_valid;
  logic        busy;
  logic        err;
  logic [11:0] digits;
  logic [1:0]  ndig;

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  logic [3:0] mq[$];
  logic [7:0] m_operand = '0;
  logic       m_err = 1'b0;

  always #5 clk = ~clk;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in),
    .btn_push(btn_push), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .operand(operand), .op_valid(op_valid), .busy(busy), .err(err),
    .digits(digits), .ndig(ndig)
  );

  function automatic logic [11:0] m_digits();
    logic [11:0] d = '0;
    foreach (mq[i]) d = {d[7:0], mq[i]};
    return d;
  endfunction

  function automatic int m_value();
    int v = 0;
    foreach (mq[i]) v = v * 10 + int'(mq[i]);
    return v;
  endfunction

  // m = {clear, enter, push}; returns expected number of op_valid pulses
  function automatic int model(logic [2:0] m, logic [3:0] d);
    int v;
    int p = 0;
    if (m[2]) begin
      mq.delete();
      m_err = 1'b0;
    end else if (m[1]) begin
      v = m_value();
      if (v <= 255) begin
        m_operand = 8'(v);
        p = 1;
      end else begin
        m_err = 1'b1;
`ifdef ENTRY_SAT_EN
        m_operand = 8'd255;
        p = 1;
`endif
      end
      mq.delete();
    end else if (m[0] && d <= 4'd9 && mq.size() < 3) begin
      mq.push_back(d);
    end
    return p;
  endfunction

  task automatic press(input logic [2:0] m, input logic [3:0] d);
    @(posedge clk); #1;
    digit_in = d;
    {btn_clear, btn_enter, btn_push} = m;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (op_valid) pulses++;
    end
    {btn_clear, btn_enter, btn_push} = 3'b000;
    repeat (6) begin
      @(posedge clk); #1;
      if (op_valid) pulses++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({operand, op_valid, busy, err, digits, ndig} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset: outputs=%h required 0",
               {operand, op_valid, busy, err, digits, ndig});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_entry_127();
    int p;
    press(3'b001, 4'd1); void'(model(3'b001, 4'd1));
    press(3'b001, 4'd2); void'(model(3'b001, 4'd2));
    press(3'b001, 4'd7); void'(model(3'b001, 4'd7));
    vectors++;
    if (digits !== 12'h127 || ndig !== 2'd3) begin
      miscompares++;
      $display("FAIL entry127_digits: digits=%h ndig=%0d required 127/3",
               digits, ndig);
    end
    @(posedge clk); #1;
    btn_enter = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 6) btn_enter = 1'b0;
      vectors++;
      if (op_valid !== (c == 8) || busy !== (c >= 5 && c <= 8)) begin
        miscompares++;
        $display("FAIL enter_timing c=%0d: op_valid=%b busy=%b required %b %b",
                 c, op_valid, busy, c == 8, c >= 5 && c <= 8);
      end
      if (c == 8) begin
        vectors++;
        if (operand !== 8'd127 || err !== 1'b0) begin
          miscompares++;
          $display("FAIL entry127_operand: operand=%0d err=%b required 127/0",
                   operand, err);
        end
      end
      if (c == 9) begin
        vectors++;
        if (digits !== 12'h0 || ndig !== 2'd0) begin
          miscompares++;
          $display("FAIL entry127_cleared: digits=%h ndig=%0d required 0/0",
                   digits, ndig);
        end
      end
    end
    p = model(3'b010, 4'd0);
  endtask

  task automatic test_overflow();
    int p;
    repeat (3) begin
      press(3'b001, 4'd9);
      void'(model(3'b001, 4'd9));
    end
    press(3'b010, 4'd0);
    p = model(3'b010, 4'd0);
    vectors++;
    if (pulses !== p || operand !== m_operand || err !== m_err) begin
      miscompares++;
      $display("FAIL overflow: pulses=%0d operand=%0d err=%b required %0d %0d %b",
               pulses, operand, err, p, m_operand, m_err);
    end
  endtask

  task automatic test_glitch_reject();
    press(3'b001, 4'd4); void'(model(3'b001, 4'd4));
    press(3'b001, 4'd5); void'(model(3'b001, 4'd5));
    digit_in = 4'd3;
    repeat (3) begin
      @(posedge clk); #1;
      btn_push = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      btn_push = 1'b0;
      repeat (6) @(posedge clk);
    end
    #1;
    vectors++;
    if (ndig !== 2'd2 || digits !== 12'h045) begin
      miscompares++;
      $display("FAIL glitch: digits=%h ndig=%0d required 045/2", digits, ndig);
    end
    press(3'b001, 4'd12); void'(model(3'b001, 4'd12));
    vectors++;
    if (ndig !== 2'd2 || digits !== m_digits()) begin
      miscompares++;
      $display("FAIL digit12: digits=%h ndig=%0d required %h/2",
               digits, ndig, m_digits());
    end
    press(3'b001, 4'd6); void'(model(3'b001, 4'd6));
    press(3'b001, 4'd7); void'(model(3'b001, 4'd7));
    vectors++;
    if (ndig !== 2'd3 || digits !== 12'h456) begin
      miscompares++;
      $display("FAIL fourth_push: digits=%h ndig=%0d required 456/3",
               digits, ndig);
    end
    press(3'b100, 4'd0); void'(model(3'b100, 4'd0));
    vectors++;
    if (err !== 1'b0 || ndig !== 2'd0 || digits !== 12'h0) begin
      miscompares++;
      $display("FAIL clear: err=%b digits=%h ndig=%0d required 0", err, digits, ndig);
    end
  endtask

  task automatic test_empty_and_abort();
    int p;
    int seen_busy = 0;
    press(3'b010, 4'd0);
    p = model(3'b010, 4'd0);
    vectors++;
    if (pulses !== 1 || operand !== 8'd0 || p !== 1) begin
      miscompares++;
      $display("FAIL empty_enter: pulses=%0d operand=%0d required 1/0", pulses, operand);
    end
    press(3'b001, 4'd8); void'(model(3'b001, 4'd8));
    @(posedge clk); #1;
    btn_enter = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn_clear = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 6) {btn_enter, btn_clear} = 2'b00;
      if (op_valid) pulses++;
      if (busy) seen_busy++;
      vectors++;
      if (busy !== (i == 3 || i == 4)) begin
        miscompares++;
        $display("FAIL abort_busy i=%0d: busy=%b required %b", i, busy, i == 3 || i == 4);
      end
    end
    mq.delete();
    vectors++;
    if (pulses !== 0 || operand !== m_operand || digits !== 12'h0 ||
        ndig !== 2'd0 || seen_busy !== 2) begin
      miscompares++;
      $display("FAIL abort: pulses=%0d operand=%0d digits=%h ndig=%0d busy_cycles=%0d required 0 %0d 0 0 2",
               pulses, operand, digits, ndig, seen_busy, m_operand);
    end
  endtask

  task automatic test_clear_push_same();
    press(3'b001, 4'd0); void'(model(3'b001, 4'd0));
    press(3'b001, 4'd4); void'(model(3'b001, 4'd4));
    press(3'b001, 4'd5); void'(model(3'b001, 4'd5));
    vectors++;
    if (digits !== 12'h045 || ndig !== 2'd3) begin
      miscompares++;
      $display("FAIL pre_clear: digits=%h ndig=%0d required 045/3", digits, ndig);
    end
    press(3'b101, 4'd3); void'(model(3'b101, 4'd3));
    vectors++;
    if (digits !== 12'h0 || ndig !== 2'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_push: digits=%h ndig=%0d err=%b required 0 0 0",
               digits, ndig, err);
    end
  endtask

  task automatic test_reset_mid_convert();
    press(3'b001, 4'd2); void'(model(3'b001, 4'd2));
    press(3'b001, 4'd0); void'(model(3'b001, 4'd0));
    @(posedge clk); #1;
    btn_enter = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_convert_busy: busy=%b required 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    btn_enter = 1'b0;
    vectors++;
    if ({operand, op_valid, busy, err, digits, ndig} !== 25'd0) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%h required 0",
               {operand, op_valid, busy, err, digits, ndig});
    end
    mq.delete();
    m_operand = '0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (op_valid) pulses++;
    end
    vectors++;
    if (pulses !== 0 || digits !== 12'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: pulses=%0d digits=%h busy=%b required 0 0 0",
               pulses, digits, busy);
    end
  endtask

  task automatic test_random();
    logic [2:0] m;
    logic [3:0] d;
    int p;
    int r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 11);
      d = 4'($urandom_range(0, 15));
      if (r <= 6) m = 3'b001;
      else if (r <= 8) m = 3'b010;
      else if (r == 9) m = 3'b100;
      else m = 3'($urandom_range(1, 7));
      if (r <= 4 && d > 9) d = d - 4'd6;
      press(m, d);
      p = model(m, d);
      vectors++;
      if (pulses !== p || operand !== m_operand || err !== m_err ||
          digits !== m_digits() || ndig !== 2'(mq.size())) begin
        miscompares++;
        $display("FAIL random n=%0d m=%b d=%0d: pulses=%0d op=%0d err=%b dig=%h nd=%0d required %0d %0d %b %h %0d",
                 n, m, d, pulses, operand, err, digits, ndig,
                 p, m_operand, m_err, m_digits(), mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry_127();
    test_overflow();
    test_glitch_reject();
    test_empty_and_abort();
    test_clear_push_same();
    test_reset_mid_convert();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_operand_entry.md
# bcd_operand_entry

Decimal keypad-style operand entry for the 8-bit ALU front end: debounces three push-buttons, collects up to three BCD digits from the switches, and converts them serially to an 8-bit binary operand. It performs the reverse of the binary-to-decimal display path and sits ahead of the operand registers. It presents a one-cycle `op_valid` strobe that loads `op1`/`op2`. The live `digits` bus feeds the existing 7-segment mux for echo.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a button change is accepted.
- `clk` in 1: system clock (100 MHz board clock).
- `rst_n` in 1: asynchronous, active-low reset.
- `digit_in` in 4: digit value from `sw[3:0]`.
- `btn_push` in 1: raw button; appends `digit_in`.
- `btn_enter` in 1: raw button; starts conversion.
- `btn_clear` in 1: raw button; discards entry or aborts conversion.
- `operand` out 8: last accepted binary value.
- `op_valid` out 1: one-cycle strobe when `operand` updates.
- `busy` out 1: high in CONVERT and DONE.
- `err` out 1: sticky out-of-range flag.
- `digits` out 12: BCD entry, [3:0] = most recently pushed digit.
- `ndig` out 2: number of digits entered, 0..3.

## Operation
- **Debounce.** Each button has its own counter (width ≥ clog2(DEBOUNCE_CYCLES+1)) and a stable bit.
  - While raw ≠ stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1, stable ← raw and the counter ← 0.
  - While raw = stable, the counter ← 0.
  - A stable 0→1 transition produces a one-cycle event (`ev_push`, `ev_enter`, `ev_clear`).
- **States:** ENTRY, CONVERT, DONE. Reset state is ENTRY.
- **ENTRY.**
  - `ev_clear`: digits ← 0, ndig ← 0, err ← 0.
  - `ev_enter` (any ndig, including 0): acc ← 0, k ← 0, go to CONVERT.
  - `ev_push` with `digit_in` ≤ 9 and ndig < 3: digits ← {digits[7:0], digit_in}, ndig + 1.
  - `ev_push` with `digit_in` > 9, or with ndig = 3: ignored, no state change.
  - Priority within one cycle: clear > enter > push. A lower-priority event in the same cycle is dropped.
- **CONVERT.**
  - Runs exactly 3 cycles for k = 0, 1, 2: acc ← acc×10 + digits[11−4k −: 4].
  - acc is 10 bits wide (max 999). Unused leading slots are 0.
  - `ev_clear` aborts to ENTRY: digits, ndig and acc cleared, no strobe, `operand` unchanged.
  - `ev_push` and `ev_enter` are ignored.
- **DONE** (1 cycle), then return to ENTRY with digits ← 0 and ndig ← 0.
  - acc ≤ 255: `operand` ← acc[7:0], `op_valid` = 1.
  - acc > 255: behaviour set by the Configuration section.
- `err` stays set until `ev_clear` in ENTRY or reset. A later successful conversion does not clear it.

## Timing
- Reset values: `operand` = 0, `op_valid` = 0, `busy` = 0, `err` = 0, `digits` = 0, `ndig` = 0. Stable bits, counters, acc and k are 0.
- Debounce latency: a raw change held constant from cycle t makes the event high in cycle t + DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES produces no event.
- The push event in cycle E updates `digits`/`ndig` from E+1.
- The enter event in cycle E:
  - state = CONVERT for E+1..E+3;
  - state = DONE in E+4, with `op_valid` and the new `operand` registered and visible in E+4;
  - state = ENTRY again from E+5.
- `busy` is high E+1..E+4.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-conversion returns immediately to ENTRY with all reset values. No strobe is produced.

## Configuration
- `ENTRY_SAT_EN` defined:
  - overflow (acc > 255) sets `operand` ← 255 and `err` ← 1;
  - `op_valid` is still pulsed in DONE.
- `ENTRY_SAT_EN` undefined:
  - overflow sets `err` ← 1;
  - `operand` keeps its previous value;
  - `op_valid` stays 0.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4.
- Push 1, 2, 7, then enter → `ndig` 3, `digits` = 0x127; `op_valid` exactly 4 cycles after the enter event; `operand` = 127, `err` = 0; `digits`/`ndig` = 0 next cycle.
- Push 9, 9, 9, then enter:
  - without macro → `op_valid` never asserts, `operand` keeps 127, `err` = 1;
  - with macro → `operand` = 255, `op_valid` pulse, `err` = 1.
- `btn_push` raw pulses of 3 cycles, then a push with `digit_in` = 12, then a fourth valid push → no digit recorded for any of them; `ndig` unchanged.
- Enter with ndig = 0 → `operand` = 0 with an `op_valid` pulse. Clear in the 2nd CONVERT cycle → no strobe, `operand` unchanged, back to ENTRY.
- Clear and push debounced in the same cycle with `digits` = 0x045 → `digits` = 0, `ndig` = 0, `err` = 0.
- `rst_n` low during CONVERT → all outputs 0 immediately (asynchronous), no `op_valid` after release.
